// File: rtl/program_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : program_counter
// Purpose  : Program-counter register for a single-cycle MIPS-style datapath.
//            It holds the address of the current instruction. On every rising
//            clk edge it loads the next-PC value chosen by the datapath. A low
//            level on nClear forces it to the reset vector at once.
// Ports    : clk     - system clock; the register loads on the rising edge
//            nClear  - asynchronous active-low clear to RESET_VALUE
//            PCnext  - next program-counter value [WIDTH-1:0]
//            PC      - current program counter [WIDTH-1:0] (registered)
// Revision : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0000
) (
    input  logic             clk,
    input  logic             nClear,
    input  logic [WIDTH-1:0] PCnext,
    output logic [WIDTH-1:0] PC
);

    // PC drives instruction memory directly from the flop. There is no
    // combinational path from PCnext, so downstream logic sees no glitches.
    // Wrap-around, alignment and stalling are all handled by the datapath.
    // The register applies no increment, masking or enable of its own.
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            PC <= RESET_VALUE;
        end else begin
            PC <= PCnext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_program_counter
// Purpose  : Directed self-checking bench for program_counter. The clock has
//            a 2 ns period, with rising edges at odd nanoseconds. PC is
//            sampled 0.5 ns after a rising edge, or at points between edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             nClear;
    logic [WIDTH-1:0] PCnext;
    logic [WIDTH-1:0] PC;

    int total = 0;
    int bad   = 0;

    program_counter #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk    (clk),
        .nClear (nClear),
        .PCnext (PCnext),
        .PC     (PC)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] expected);
        total++;
        assert (PC === expected)
        else begin
            bad++;
            $error("FAIL %s: PC=%h expected=%h", tag, PC, expected);
        end
    endtask

    // One clock period; keeps the sample point 0.5 ns after a rising edge.
    task automatic step();
        #2;
    endtask

    // Stimulus is purely time-driven. This watchdog only guards against an
    // unexpected stall of the simulation itself.
    initial begin
        #1000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-up clear: clk toggles and PCnext changes, but PC stays at 0.
        nClear = 1'b0;
        PCnext = 16'h0001;
        #0.5 chk("pwrup_t0", 16'h0000);              // t=0.5
        #1   chk("pwrup_e1", 16'h0000);              // t=1.5, after edge 1
        PCnext = 16'h0005;
        #2   chk("pwrup_e3", 16'h0000);              // t=3.5, after edge 3
        #1.5 nClear = 1'b1;                          // t=5, races edge 5
        #2.5 chk("load_e7", 16'h0005);               // t=7.5, after edge 7
        step(); chk("hold_e9",  16'h0005);
        step(); chk("hold_e11", 16'h0005);

        // Sequential loads: PC follows PCnext one edge later.
        PCnext = 16'h0002; step(); chk("seq_0002", 16'h0002);
        PCnext = 16'h0004; step(); chk("seq_0004", 16'h0004);
        PCnext = 16'h0100; step(); chk("seq_0100", 16'h0100);

        // Asynchronous clear between edges.
        PCnext = 16'h1234; step(); chk("pre_clr_1234", 16'h1234); // t=19.5
        #0.5 nClear = 1'b0;                          // t=20, no rising edge
        PCnext = 16'hBEEF;
        #0.1 chk("clr_immediate", 16'h0000);         // t=20.1
        #1.4 chk("clr_edge1", 16'h0000);             // t=21.5
        #2   chk("clr_edge2", 16'h0000);             // t=23.5
        #0.5 nClear = 1'b1;                          // t=24, between edges
        PCnext = 16'hFFFF;

        // Full-width capture and wrap pass-through.
        #1.5 chk("wide_ffff", 16'hFFFF);             // t=25.5
        PCnext = 16'h0000; step(); chk("wrap_0000", 16'h0000);
        PCnext = 16'hA5A5; step(); chk("pat_a5a5",  16'hA5A5);
        PCnext = 16'h5A5A; step(); chk("pat_5a5a",  16'h5A5A);

        // A PCnext change between edges has no effect until the next edge.
        PCnext = 16'h0010; step(); chk("mid_0010", 16'h0010);
        #0.7 PCnext = 16'h0020;
        #0.6 chk("mid_hold", 16'h0010);              // still before the edge
        #0.7 chk("mid_0020", 16'h0020);              // 0.5 ns after the edge

        // A short clear pulse between edges discards the loaded value.
        #0.5 nClear = 1'b0;
        #0.2 chk("pulse_clr", 16'h0000);
        #0.2 nClear = 1'b1;
        #0.4 chk("pulse_hold", 16'h0000);            // before the next edge
        PCnext = 16'h0042;
        #0.7 chk("pulse_reload", 16'h0042);          // 0.5 ns after the edge

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_counter.md
# program_counter

16-bit program-counter register for the single-cycle MIPS-style datapath. It holds the address of the current instruction and drives it to instruction memory and the PC-increment/branch logic. Each rising clock edge it loads the next-PC value computed by the datapath. An asynchronous active-low clear forces it back to the reset vector.

## Interface
Parameters:
- WIDTH, 16: PC / PCnext bit width.
- RESET_VALUE, 16'h0000: value forced onto PC while clear is asserted.

Ports (clock and reset first):
- clk  input  1  system clock; all state changes occur on its rising edge except clear.
- nClear  input  1  reset; one clock; reset is asynchronous and active-low.
- PCnext  input  WIDTH  next program-counter value from the datapath next-PC mux.
- PC  output  WIDTH  current program counter; registered output, no combinational path from PCnext.

## Operation
- Single WIDTH-bit register; PC is the register's output.
- nClear low: PC is forced to RESET_VALUE immediately, regardless of clk. PC is held there for as long as nClear stays low. Clock edges and PCnext are ignored.
- nClear high, rising clk edge: PC <= PCnext, all WIDTH bits, unmodified.
  - No increment, alignment, masking or saturation inside the block.
  - Wrap-around (0xFFFF -> 0x0000) is the datapath's responsibility and passes through unchanged.
- Between rising edges, PC holds its value. Changes on PCnext between edges have no effect on PC.
- No enable or stall input. A load occurs on every rising edge while nClear is high.
- X/Z on PCnext is captured as-is. No checking is performed.

## Timing
- Reset value: PC = RESET_VALUE (0x0000) from nClear assertion, with no clock needed.
- Clear assertion mid-cycle: PC goes to 0x0000 within the same simulation time step as the nClear falling edge. Any value loaded earlier is discarded.
- Clear release: synchronous behaviour resumes from the first rising clk edge at which nClear is already high.
- A rising clk edge coincident with nClear release is a race. PC after that edge is either RESET_VALUE or PCnext; both are compliant. Benches check PC only from the following edge.
- Load latency: PCnext sampled at rising edge N appears on PC after edge N (clock-to-Q), and is stable until edge N+1.
- PCnext setup/hold relative to the rising edge is the only input timing requirement.
- PC does not glitch between edges.

## Test plan
- Power-up clear: nClear=0, PCnext=0x0001 then 0x0005, clk toggling 2 ns period for 5 ns -> PC = 0x0000 throughout.
- Load after release: nClear=1 at t=5, PCnext=0x0005 -> PC = 0x0005 after the rising edge at t=7, and holds on later edges while PCnext is unchanged.
- Sequential loads: PCnext = 0x0002, 0x0004, 0x0100 on consecutive edges -> PC follows one edge later: 0x0002, 0x0004, 0x0100.
- Asynchronous clear mid-cycle: PC=0x1234, drop nClear between edges -> PC = 0x0000 immediately. PC remains 0x0000 across two edges with PCnext=0xBEEF while nClear is low.
- Width/wrap: PCnext=0xFFFF then 0x0000 -> PC = 0xFFFF, then 0x0000; all 16 bits captured exactly.
- Mid-cycle PCnext change: change PCnext 0x0010 -> 0x0020 between edges -> PC is unchanged until the next rising edge, then 0x0020.
